// File: rtl/capture_addr_sequencer.sv
// capture_addr_sequencer: SDRAM write-address generator for scope capture.
// Circular pre-trigger buffer. It latches the trigger address, writes POST_COUNT
// more samples, then parks in DONE. Nios reaches it through a 4-word
// Avalon-MM slave.
// Optional build macro CAPTURE_SEQ_IRQ_EN adds a completion interrupt (irq).
module capture_addr_sequencer #(
    parameter int              ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              sample_valid,
    input  logic              trigger,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
`ifdef CAPTURE_SEQ_IRQ_EN
    output logic              irq,
`endif
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_post_count;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic              r_wrapped;
    logic              r_irq_en;

    logic w_reg_wr;
    logic w_ctrl_wr;
    logic w_arm;
    logic w_abort;
    logic w_wr_en;
    logic w_at_max;
    logic w_enter_done;
    logic w_unused;

    assign w_reg_wr  = chipselect & ~write_n;
    assign w_ctrl_wr = w_reg_wr & (address == 2'd0);
    assign w_arm     = w_ctrl_wr & writedata[0];
    assign w_abort   = w_ctrl_wr & writedata[1];
    assign w_wr_en   = sample_valid & ((r_state == S_PRE) | (r_state == S_POST));
    assign w_at_max  = (r_addr == MAX_ADDR);
    // The last sample of a capture: a trigger with no post samples, or the final post sample.
    // Abort wins over completion, so it also blocks the transition.
    assign w_enter_done = ~w_abort & w_wr_en &
                          (((r_state == S_PRE) & trigger & (r_post_count == '0)) |
                           ((r_state == S_POST) & (r_remaining == ADDR_W'(1))));
    assign w_unused  = ^writedata[31:ADDR_W];

    assign wr_en   = w_wr_en;
    assign wr_addr = r_addr;
    assign done    = (r_state == S_DONE);

    // Capture FSM, address counter and register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_post_count <= '0;
            r_trig_addr  <= '0;
            r_remaining  <= '0;
            r_wrapped    <= 1'b0;
        end else begin
            // The trigger below reads the old POST_COUNT, so a same-cycle write lands next time.
            if (w_reg_wr && address == 2'd1)
                r_post_count <= writedata[ADDR_W-1:0];
            if (w_abort) begin
                // Abort freezes counter, trigger address and remaining. Only the state changes.
                r_state <= S_IDLE;
            end else if (w_arm && (r_state == S_IDLE || r_state == S_DONE)) begin
                r_state     <= S_PRE;
                r_addr      <= '0;
                r_wrapped   <= 1'b0;
                r_remaining <= '0;
            end else if (w_wr_en) begin
                r_addr <= w_at_max ? '0 : r_addr + 1'b1;
                if (r_state == S_PRE) begin
                    if (w_at_max)
                        r_wrapped <= 1'b1;
                    if (trigger) begin
                        r_trig_addr <= r_addr;
                        if (r_post_count == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state     <= S_POST;
                            r_remaining <= r_post_count;
                        end
                    end
                end else begin
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == ADDR_W'(1))
                        r_state <= S_DONE;
                end
            end
        end
    end

`ifdef CAPTURE_SEQ_IRQ_EN
    logic r_irq;
    assign irq = r_irq;

    // Completion interrupt. An ack, arm or abort clears it, and the clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq    <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_ctrl_wr)
                r_irq_en <= writedata[2];
            if (w_ctrl_wr && (writedata[3] || writedata[1] || writedata[0]))
                r_irq <= 1'b0;
            else if (w_enter_done && r_irq_en)
                r_irq <= 1'b1;
        end
    end
`else
    assign r_irq_en = 1'b0;
    logic w_unused_done;
    assign w_unused_done = w_enter_done;
`endif

    // Zero-wait-state read mux.
    always_comb begin
        readdata = '0;
        case (address)
            2'd1: readdata = 32'(r_post_count);
            2'd2: readdata = {27'd0, r_irq_en, r_wrapped, (r_state == S_DONE), r_state};
            2'd3: readdata = 32'(r_trig_addr);
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_capture_addr_sequencer.sv
// Bench for capture_addr_sequencer with MAX_ADDR=15. It applies a vector table,
// then directed corner sequences, then random traffic checked against a rule-level model.
module tb_capture_addr_sequencer;

    localparam int MAXA = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect, write_n, sample_valid, trigger;
    logic [31:0] writedata, readdata;
    logic        wr_en, done;
    logic [19:0] wr_addr;
`ifdef CAPTURE_SEQ_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    capture_addr_sequencer #(.ADDR_W(20), .MAX_ADDR(20'd15)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .sample_valid(sample_valid), .trigger(trigger), .wr_en(wr_en),
        .wr_addr(wr_addr),
`ifdef CAPTURE_SEQ_IRQ_EN
        .irq(irq),
`endif
        .done(done));

    int vectors = 0, miscompares = 0, nwr = 0;
    logic        last_en;
    logic [31:0] last_addr;

    // Reference model. States: 0 idle, 1 pre, 2 post, 3 done.
    int m_state = 0, m_addr = 0, m_post = 0, m_trig = 0, m_rem = 0;
    bit m_wrap = 0, m_irqen = 0, m_irq = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        logic [31:0] v;
        v = 0;
        case (a)
            2'd1: v = m_post;
            2'd2: v = {27'd0, m_irqen, m_wrap, (m_state == 3), m_state[1:0]};
            2'd3: v = m_trig;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic model_step();
        bit we, arm, abort, wr, enter, was_pre;
        int old_post;
        if (reset) begin
            m_state = 0; m_addr = 0; m_post = 0; m_trig = 0; m_rem = 0;
            m_wrap = 0; m_irqen = 0; m_irq = 0;
            return;
        end
        we = chipselect && !write_n;
        arm = we && address == 0 && writedata[0];
        abort = we && address == 0 && writedata[1];
        wr = sample_valid && (m_state == 1 || m_state == 2);
        enter = 0;
        old_post = m_post;
        if (we && address == 1) m_post = int'(writedata[19:0]);
        if (abort) m_state = 0;
        else if (arm && (m_state == 0 || m_state == 3)) begin
            m_state = 1; m_addr = 0; m_wrap = 0; m_rem = 0;
        end else if (wr) begin
            was_pre = (m_state == 1);
            if (was_pre && trigger) begin
                m_trig = m_addr;
                if (old_post == 0) begin m_state = 3; enter = 1; end
                else begin m_state = 2; m_rem = old_post; end
            end else if (!was_pre) begin
                m_rem--;
                if (m_rem == 0) begin m_state = 3; enter = 1; end
            end
            if (was_pre && m_addr == MAXA) m_wrap = 1;
            m_addr = (m_addr + 1) % (MAXA + 1);
        end
`ifdef CAPTURE_SEQ_IRQ_EN
        if (we && address == 0 && (writedata[3] || writedata[1] || writedata[0])) m_irq = 0;
        else if (enter && m_irqen) m_irq = 1;
        if (we && address == 0) m_irqen = writedata[2];
`endif
    endtask

    task automatic check_model();
        chk("wr_en", {31'd0, wr_en}, {31'd0, sample_valid && (m_state == 1 || m_state == 2)});
        chk("wr_addr", {12'd0, wr_addr}, m_addr);
        chk("done", {31'd0, done}, {31'd0, m_state == 3});
        chk("readdata", readdata, model_rd(address));
`ifdef CAPTURE_SEQ_IRQ_EN
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
        if (wr_en === 1'b1) nwr++;
        last_en = wr_en;
        last_addr = {12'd0, wr_addr};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // One cycle: drive, check against the model mid-cycle, then advance.
    task automatic cyc(input bit sv, input bit trg, input bit w, input logic [1:0] a, input logic [31:0] wd);
        sample_valid = sv; trigger = trg; chipselect = w; write_n = ~w;
        address = a; writedata = wd;
        #2;
        check_model();
        tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        cyc(0, 0, 1, a, wd);
    endtask

    // Read a register in the current cycle and compare it with a fixed expected value.
    task automatic peek(input logic [1:0] a, input string nm, input logic [31:0] exp);
        sample_valid = 0; trigger = 0; chipselect = 0; write_n = 1; address = a; writedata = 0;
        #2;
        chk(nm, readdata, exp);
        check_model();
        tick();
    endtask

    typedef struct {
        bit sv; bit trg; bit w; logic [1:0] a; logic [31:0] wd;
        bit e_en; int e_addr; bit e_done; logic [31:0] e_rd;
    } vec_t;

    initial begin
        vec_t tbl[16];
        // Reset readback with POST_COUNT=5, then ARM, trigger on the 4th sample and 5 post samples.
        tbl[0]  = '{0,0,1,2'd1,5, 0,0,0,0};
        tbl[1]  = '{0,0,0,2'd1,0, 0,0,0,5};
        tbl[2]  = '{0,0,0,2'd2,0, 0,0,0,0};
        tbl[3]  = '{0,0,0,2'd3,0, 0,0,0,0};
        tbl[4]  = '{0,0,1,2'd0,1, 0,0,0,0};
        tbl[5]  = '{1,0,0,2'd2,0, 1,0,0,1};
        tbl[6]  = '{1,0,0,2'd2,0, 1,1,0,1};
        tbl[7]  = '{1,0,0,2'd2,0, 1,2,0,1};
        tbl[8]  = '{1,1,0,2'd2,0, 1,3,0,1};
        tbl[9]  = '{1,0,0,2'd2,0, 1,4,0,2};
        tbl[10] = '{1,0,0,2'd3,0, 1,5,0,3};
        tbl[11] = '{1,0,0,2'd2,0, 1,6,0,2};
        tbl[12] = '{1,0,0,2'd2,0, 1,7,0,2};
        tbl[13] = '{1,0,0,2'd2,0, 1,8,0,2};
        tbl[14] = '{1,0,0,2'd2,0, 0,9,1,7};
        tbl[15] = '{0,0,0,2'd3,0, 0,9,1,3};

        reset = 1; sample_valid = 0; trigger = 0; chipselect = 0; write_n = 1;
        address = 0; writedata = 0;
        repeat (2) tick();
        reset = 0;

        foreach (tbl[i]) begin
            sample_valid = tbl[i].sv; trigger = tbl[i].trg; chipselect = tbl[i].w;
            write_n = ~tbl[i].w; address = tbl[i].a; writedata = tbl[i].wd;
            #2;
            chk($sformatf("tbl%0d_wr_en", i), {31'd0, wr_en}, {31'd0, tbl[i].e_en});
            chk($sformatf("tbl%0d_wr_addr", i), {12'd0, wr_addr}, tbl[i].e_addr);
            chk($sformatf("tbl%0d_done", i), {31'd0, done}, {31'd0, tbl[i].e_done});
            chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].e_rd);
            tick();
        end

        // Wrap: 20 PRE samples, trigger at address 4, POST_COUNT=2.
        wr(1, 2); wr(0, 1);
        repeat (20) cyc(1, 0, 0, 2, 0);
        cyc(1, 1, 0, 3, 0);
        chk("wrap_trig_sample", last_addr, 4);
        cyc(1, 0, 0, 2, 0);
        cyc(1, 0, 0, 2, 0);
        chk("wrap_last_addr", last_addr, 6);
        peek(2, "wrap_status", 32'hF);
        peek(3, "wrap_trig", 4);

        // POST_COUNT=0 with trigger on the first sample gives exactly one write.
        wr(1, 0); wr(0, 1);
        nwr = 0;
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 2, 0);
        chk("p0_writes", nwr, 1);
        peek(2, "p0_status", 7);
        peek(3, "p0_trig", 0);

        // A trigger without sample_valid is ignored.
        wr(0, 1);
        cyc(0, 1, 0, 2, 0);
        peek(2, "trig_nosv", 1);

        // Gaps in sample_valid during POST still give 5 post writes.
        wr(1, 5);
        nwr = 0;
        cyc(1, 1, 0, 2, 0);
        for (int i = 0; i < 20; i++) cyc(i % 2 == 0, 0, 0, 2, 0);
        chk("gap_writes", nwr, 6);
        peek(2, "gap_status", 7);

        // ABORT during POST.
        wr(0, 1);
        cyc(1, 1, 0, 2, 0);
        cyc(1, 0, 0, 2, 0);
        wr(0, 2);
        peek(2, "abort_idle", 0);
        cyc(1, 0, 0, 2, 0);
        chk("abort_wren", {31'd0, last_en}, 0);

        // ARM and ABORT in the same write leave the block in IDLE.
        wr(0, 1);
        wr(0, 3);
        peek(2, "armabort", 0);

        // ARM during PRE is ignored.
        wr(0, 1);
        repeat (3) cyc(1, 0, 0, 2, 0);
        wr(0, 1);
        cyc(1, 0, 0, 2, 0);
        chk("arm_pre_addr", last_addr, 3);
        peek(2, "arm_pre_status", 1);

        // Reset in the middle of POST.
        wr(1, 5);
        cyc(1, 1, 0, 2, 0);
        cyc(1, 0, 0, 2, 0);
        reset = 1;
        cyc(1, 0, 0, 2, 0);
        reset = 0;
        cyc(1, 0, 0, 1, 0);
        chk("rst_wren", {31'd0, last_en}, 0);
        chk("rst_addr", last_addr, 0);
        peek(1, "rst_post", 0);
        peek(2, "rst_status", 0);

        // Random traffic checked against the model.
        for (int i = 0; i < 600; i++) begin
            logic [1:0] a;
            a = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 249) == 0);
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0,
                $urandom_range(0, 11) == 0, a,
                (a == 1) ? $urandom_range(0, 6) : $urandom_range(0, 15));
            reset = 0;
        end

`ifdef CAPTURE_SEQ_IRQ_EN
        // Interrupt: enable, finish a capture, then acknowledge it.
        wr(0, 2); wr(1, 1); wr(0, 5);
        cyc(1, 1, 0, 2, 0);
        cyc(1, 0, 0, 2, 0);
        chk("irq_set", {31'd0, irq}, 1);
        peek(2, "irq_status", 32'h17);
        wr(0, 8);
        chk("irq_ack", {31'd0, irq}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
